smsub_serial: RTL and testbench

- Bit-serial sign-magnitude subtractor, y = a - b, for W-bit sign-magnitude operands (1 sign bit, W-1 magnitude bits).
- Counterpart to the combinational sign-magnitude adder. It negates b's sign internally and processes one magnitude bit per clock.
- Start/ready/done handshake; shares one serial adder cell between the subtract pass and an optional re-negate pass.
- Sits on the datapath where area matters more than latency.

---
 rtl/smsub_pkg.sv | 17 +
 rtl/smsub_serial_if.sv | 24 ++
 rtl/serial_bit_adder.sv | 26 ++
 rtl/smsub_serial.sv | 148 ++++++++++++++
 tb/tb_smsub_serial.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/smsub_pkg.sv
// rtl/smsub_pkg.sv - shared types and constants for the bit-serial sign-magnitude subtractor
package smsub_pkg;

  // Default total operand width (1 sign bit + magnitude bits)
  localparam int W_DEFAULT = 4;

  // Bit counter width for the default operand width
  localparam int CNT_W = $clog2(W_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/smsub_serial_if.sv
// rtl/smsub_serial_if.sv - start/ready/done handshake and operand/result bundle
interface smsub_serial_if #(
  parameter int W = 4
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] y;
  logic         ovf;

  modport master (
    output start, a, b,
    input  ready, done, y, ovf
  );

  modport slave (
    input  start, a, b,
    output ready, done, y, ovf
  );

endinterface

// File: rtl/serial_bit_adder.sv
// rtl/serial_bit_adder.sv - one-bit full adder with a registered, seedable carry
module serial_bit_adder (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic cin_init,
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ c;

  // Carry register: seeded on load, otherwise takes this bit's carry-out
  always_ff @(posedge clk) begin
    if (reset) begin
      c <= 1'b0;
    end else if (load) begin
      c <= cin_init;
    end else begin
      c <= (x & y) | (c & (x ^ y));
    end
  end

endmodule

// File: rtl/smsub_serial.sv
// rtl/smsub_serial.sv - bit-serial sign-magnitude subtractor y = a - b
module smsub_serial
  import smsub_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  smsub_serial_if.slave bus
);

  localparam int M  = W - 1;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(M - 1);

  state_t state, next_state;

  logic [M-1:0]  ma, mb, mr;
  logic          a_sign, sbe, op_sub;
  logic [CW-1:0] cnt;
  logic [W-1:0]  y_q;
  logic          ovf_q;

  logic          load, cin_init;
  logic          cx, cy, s, c;
  logic          cout_now, last, ovf_hit, finish;
  logic [M-1:0]  mr_next, fin_mag;
  logic          fin_sign;

  serial_bit_adder u_cell (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .cin_init (cin_init),
    .x        (cx),
    .y        (cy),
    .s        (s),
    .c        (c)
  );

  assign last     = (cnt == LAST_BIT);
  // Carry-out of the bit in flight; on the last ADD bit this is the final carry
  assign cout_now = (cx & cy) | (c & (cx ^ cy));
  assign ovf_hit  = ~op_sub & cout_now;
  assign mr_next  = {s, mr[M-1:1]};
  assign fin_mag  = (state == ADD && ovf_hit) ? '1 : mr_next;
  assign fin_sign = (state == NEG) ? sbe : a_sign;
  assign finish   = last && ((state == NEG) || (state == ADD && next_state == DONE));

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == DONE);
  assign bus.y     = y_q;
  assign bus.ovf   = ovf_q;

  // Cell operand select: magnitude add (b conditionally inverted) or two's-complement re-negate
  always_comb begin
    cx = 1'b0;
    cy = 1'b0;
    if (state == ADD) begin
      cx = ma[0];
      cy = mb[0] ^ op_sub;
    end else if (state == NEG) begin
      cx = ~mr[0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and carry seeding
  always_comb begin
    next_state = state;
    load       = 1'b0;
    cin_init   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = ADD;
          load       = 1'b1;
          cin_init   = bus.a[W-1] ^ ~bus.b[W-1];
        end
      end
      ADD: begin
        if (last) begin
          if (op_sub && !cout_now) begin
            next_state = NEG;
            load       = 1'b1;
            cin_init   = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      NEG: begin
        if (last) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, shift registers, bit counter and result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ma     <= '0;
      mb     <= '0;
      mr     <= '0;
      a_sign <= 1'b0;
      sbe    <= 1'b0;
      op_sub <= 1'b0;
      cnt    <= '0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ma     <= bus.a[M-1:0];
            mb     <= bus.b[M-1:0];
            a_sign <= bus.a[W-1];
            sbe    <= ~bus.b[W-1];
            op_sub <= bus.a[W-1] ^ ~bus.b[W-1];
            cnt    <= '0;
          end
        end
        ADD: begin
          ma  <= ma >> 1;
          mb  <= mb >> 1;
          mr  <= mr_next;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        NEG: begin
          mr  <= mr_next;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
      if (finish) begin
        y_q   <= {fin_sign & (|fin_mag), fin_mag};
        ovf_q <= (state == ADD) && ovf_hit;
      end
    end
  end

endmodule

// File: tb/tb_smsub_serial.sv
// tb/tb_smsub_serial.sv - directed self-checking bench for smsub_serial
module tb_smsub_serial;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  smsub_serial_if #(.W(4)) bus ();

  smsub_serial #(.W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; no checking here
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                        output logic [3:0] ry, output logic rovf,
                        output int lat, output logic ready_seen);
    @(negedge clk);
    bus.a = ta;
    bus.b = tb_v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~ta;
    bus.b = ~tb_v;
    lat = 1;
    ready_seen = 1'b0;
    while (!bus.done && lat < 30) begin
      if (bus.ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (bus.ready) ready_seen = 1'b1;
    ry = bus.y;
    rovf = bus.ovf;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.y !== 4'b0000) begin bad++; $display("FAIL reset_y got=%b want=0000", bus.y); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_path();
    logic [3:0] ry; logic rovf; int lat; logic rs;
    run_op(4'b0011, 4'b0001, ry, rovf, lat, rs);
    total++; if (ry !== 4'b0010) begin bad++; $display("FAIL add_y got=%b want=0010", ry); end
    total++; if (rovf !== 1'b0) begin bad++; $display("FAIL add_ovf got=%b want=0", rovf); end
    total++; if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d want=4", lat); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL add_ready_low got=%b want=0", rs); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b want=0", bus.done); end
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL add_ready_back got=%b want=1", bus.ready); end
    total++; if (bus.y !== 4'b0010) begin bad++; $display("FAIL add_y_hold got=%b want=0010", bus.y); end
  endtask

  task automatic test_neg_path();
    logic [3:0] ry; logic rovf; int lat; logic rs;
    run_op(4'b0001, 4'b0011, ry, rovf, lat, rs);
    total++; if (ry !== 4'b1010) begin bad++; $display("FAIL neg_y got=%b want=1010", ry); end
    total++; if (rovf !== 1'b0) begin bad++; $display("FAIL neg_ovf got=%b want=0", rovf); end
    total++; if (lat !== 7) begin bad++; $display("FAIL neg_latency got=%0d want=7", lat); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL neg_ready_low got=%b want=0", rs); end
  endtask

  task automatic test_overflow();
    logic [3:0] ry; logic rovf; int lat; logic rs;
    run_op(4'b0101, 4'b1101, ry, rovf, lat, rs);
    total++; if (ry !== 4'b0111) begin bad++; $display("FAIL ovf_pos_y got=%b want=0111", ry); end
    total++; if (rovf !== 1'b1) begin bad++; $display("FAIL ovf_pos_flag got=%b want=1", rovf); end
    total++; if (lat !== 4) begin bad++; $display("FAIL ovf_pos_latency got=%0d want=4", lat); end
    run_op(4'b1101, 4'b0101, ry, rovf, lat, rs);
    total++; if (ry !== 4'b1111) begin bad++; $display("FAIL ovf_neg_y got=%b want=1111", ry); end
    total++; if (rovf !== 1'b1) begin bad++; $display("FAIL ovf_neg_flag got=%b want=1", rovf); end
    @(negedge clk);
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%b want=1", bus.ovf); end
  endtask

  task automatic test_zero_norm();
    logic [3:0] ry; logic rovf; int lat; logic rs;
    run_op(4'b1010, 4'b1010, ry, rovf, lat, rs);
    total++; if (ry !== 4'b0000) begin bad++; $display("FAIL zero_m2m2_y got=%b want=0000", ry); end
    total++; if (rovf !== 1'b0) begin bad++; $display("FAIL zero_m2m2_ovf got=%b want=0", rovf); end
    run_op(4'b1000, 4'b0000, ry, rovf, lat, rs);
    total++; if (ry !== 4'b0000) begin bad++; $display("FAIL zero_m0_y got=%b want=0000", ry); end
    total++; if (rovf !== 1'b0) begin bad++; $display("FAIL zero_m0_ovf got=%b want=0", rovf); end
    total++; if (lat !== 4) begin bad++; $display("FAIL zero_m0_latency got=%0d want=4", lat); end
  endtask

  task automatic test_ignored_start();
    int lat;
    int extra_done;
    @(negedge clk);
    bus.a = 4'b0011;
    bus.b = 4'b0001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 4'b0001;
    bus.b = 4'b0011;
    lat = 1;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL ign_latency got=%0d want=4", lat); end
    total++; if (bus.y !== 4'b0010) begin bad++; $display("FAIL ign_y got=%b want=0010", bus.y); end
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    total++; if (extra_done !== 0) begin bad++; $display("FAIL ign_no_queue got=%0d want=0", extra_done); end
    total++; if (bus.y !== 4'b0010) begin bad++; $display("FAIL ign_y_hold got=%b want=0010", bus.y); end
  endtask

  task automatic test_reset_mid_neg();
    logic [3:0] ry; logic rovf; int lat; logic rs;
    int seen_done;
    @(negedge clk);
    bus.a = 4'b0001;
    bus.b = 4'b0011;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rst_neg_ready got=%b want=1", bus.ready); end
    total++; if (bus.y !== 4'b0000) begin bad++; $display("FAIL rst_neg_y got=%b want=0000", bus.y); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL rst_neg_ovf got=%b want=0", bus.ovf); end
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) seen_done++;
      @(negedge clk);
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL rst_neg_no_done got=%0d want=0", seen_done); end
    run_op(4'b0110, 4'b0010, ry, rovf, lat, rs);
    total++; if (ry !== 4'b0100) begin bad++; $display("FAIL rst_after_y got=%b want=0100", ry); end
    total++; if (lat !== 4) begin bad++; $display("FAIL rst_after_latency got=%0d want=4", lat); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_add_path();
    test_neg_path();
    test_overflow();
    test_zero_norm();
    test_ignored_start();
    test_reset_mid_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
